// File: rtl/ps2_char_writer.sv
// ps2_char_writer: turns PS/2 set-2 scancodes into character-buffer writes.
// Decodes make/break/extended prefixes, tracks Shift, maintains a cursor, and
// runs a full-buffer blanking sweep on request.
// Optional feature macro: TYPEMATIC_FILTER_EN (suppress auto-repeat makes of
// the last printable/Backspace key until its break code arrives).
//
// Handshake: read_data is a one-cycle strobe qualifying rx_data and err in
// the same cycle; there is no back-pressure, so bytes arriving while busy=1
// (or together with clear) are dropped. wr_en is a one-cycle write pulse
// qualifying wr_addr and wr_char; the buffer is assumed always ready.
`timescale 1ns/1ps

module ps2_char_writer #(
  parameter int BUFFER_WIDTH = 12,
  parameter int BUFFER_CELLS = 108,
  parameter int ADDR_W       = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              read_data,
  input  logic              err,
  input  logic              clear,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_char,
  output logic [ADDR_W-1:0] cursor,
  output logic              shift_active,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_EXT       = 2'd1,
    ST_BREAK     = 2'd2,
    ST_EXT_BREAK = 2'd3
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(BUFFER_CELLS - 1);
  localparam logic [31:0]       ROW_W     = 32'(BUFFER_WIDTH);
  localparam logic [31:0]       CELLS_32  = 32'(BUFFER_CELLS);

  state_t              state_q, state_d;
  logic                shift_q, shift_d;
  logic                busy_q, busy_d;
  logic [ADDR_W-1:0]   cursor_q, cursor_d;
  logic [ADDR_W-1:0]   clr_cnt_q, clr_cnt_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_char_q, wr_char_d;
`ifdef TYPEMATIC_FILTER_EN
  logic [7:0]          last_key_q, last_key_d;
  logic                last_valid_q, last_valid_d;
`endif

  logic                repeat_hit;
  logic                is_shift_code;
  logic [7:0]          letter_lc;
  logic [7:0]          digit_ch;
  logic                print_ok;
  logic [7:0]          print_char;
  logic [ADDR_W-1:0]   cur_inc, cur_dec, enter_pos;
  logic [31:0]         cur_ext, row_next;

  // Lowercase ASCII for a set-2 letter code, 0 when not a letter.
  function automatic logic [7:0] letter_lc_of(input logic [7:0] code);
    case (code)
      8'h1C: letter_lc_of = 8'h61;  8'h32: letter_lc_of = 8'h62;
      8'h21: letter_lc_of = 8'h63;  8'h23: letter_lc_of = 8'h64;
      8'h24: letter_lc_of = 8'h65;  8'h2B: letter_lc_of = 8'h66;
      8'h34: letter_lc_of = 8'h67;  8'h33: letter_lc_of = 8'h68;
      8'h43: letter_lc_of = 8'h69;  8'h3B: letter_lc_of = 8'h6A;
      8'h42: letter_lc_of = 8'h6B;  8'h4B: letter_lc_of = 8'h6C;
      8'h3A: letter_lc_of = 8'h6D;  8'h31: letter_lc_of = 8'h6E;
      8'h44: letter_lc_of = 8'h6F;  8'h4D: letter_lc_of = 8'h70;
      8'h15: letter_lc_of = 8'h71;  8'h2D: letter_lc_of = 8'h72;
      8'h1B: letter_lc_of = 8'h73;  8'h2C: letter_lc_of = 8'h74;
      8'h3C: letter_lc_of = 8'h75;  8'h2A: letter_lc_of = 8'h76;
      8'h1D: letter_lc_of = 8'h77;  8'h22: letter_lc_of = 8'h78;
      8'h35: letter_lc_of = 8'h79;  8'h1A: letter_lc_of = 8'h7A;
      default: letter_lc_of = 8'h00;
    endcase
  endfunction

  // ASCII digit for a set-2 digit code, 0 when not a digit.
  function automatic logic [7:0] digit_of(input logic [7:0] code);
    case (code)
      8'h45: digit_of = 8'h30;  8'h16: digit_of = 8'h31;
      8'h1E: digit_of = 8'h32;  8'h26: digit_of = 8'h33;
      8'h25: digit_of = 8'h34;  8'h2E: digit_of = 8'h35;
      8'h36: digit_of = 8'h36;  8'h3D: digit_of = 8'h37;
      8'h3E: digit_of = 8'h38;  8'h46: digit_of = 8'h39;
      default: digit_of = 8'h00;
    endcase
  endfunction

  // Cursor neighbours: wrapping step forward/back and start of next row.
  assign cur_inc   = (cursor_q == LAST_CELL) ? '0 : cursor_q + ADDR_W'(1);
  assign cur_dec   = (cursor_q == '0) ? LAST_CELL : cursor_q - ADDR_W'(1);
  assign cur_ext   = 32'(cursor_q);
  assign row_next  = ((cur_ext / ROW_W) + 32'd1) * ROW_W;
  assign enter_pos = (row_next >= CELLS_32) ? '0 : row_next[ADDR_W-1:0];

  assign is_shift_code = (rx_data == 8'h12) || (rx_data == 8'h59);

`ifdef TYPEMATIC_FILTER_EN
  assign repeat_hit = last_valid_q && (rx_data == last_key_q);
`else
  assign repeat_hit = 1'b0;
`endif

  // Printable-character lookup for the current byte, honouring Shift on letters.
  always_comb begin
    letter_lc  = letter_lc_of(rx_data);
    digit_ch   = digit_of(rx_data);
    print_ok   = 1'b1;
    print_char = 8'h20;
    if (letter_lc != 8'h00) begin
      print_char = shift_q ? (letter_lc - 8'h20) : letter_lc;
    end else if (digit_ch != 8'h00) begin
      print_char = digit_ch;
    end else if (rx_data == 8'h29) begin
      print_char = 8'h20;
    end else begin
      print_ok = 1'b0;
    end
  end

  // Next-state logic: clear sweep has priority, then byte decode.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    busy_d    = busy_q;
    cursor_d  = cursor_q;
    clr_cnt_d = clr_cnt_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_char_d = wr_char_q;
`ifdef TYPEMATIC_FILTER_EN
    last_key_d   = last_key_q;
    last_valid_d = last_valid_q;
`endif
    if (busy_q) begin
      // Sweep in progress: clr_cnt_q is the cell written this cycle.
      if (clr_cnt_q == LAST_CELL) begin
        busy_d    = 1'b0;
        clr_cnt_d = '0;
        cursor_d  = '0;
      end else begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        wr_en_d   = 1'b1;
        wr_addr_d = clr_cnt_q + ADDR_W'(1);
        wr_char_d = 8'h20;
      end
    end else if (clear) begin
      busy_d    = 1'b1;
      clr_cnt_d = '0;
      wr_en_d   = 1'b1;
      wr_addr_d = '0;
      wr_char_d = 8'h20;
    end else if (read_data && err) begin
      state_d = ST_IDLE;
    end else if (read_data) begin
      case (state_q)
        ST_IDLE: begin
          if (rx_data == 8'hF0) begin
            state_d = ST_BREAK;
          end else if (rx_data == 8'hE0) begin
            state_d = ST_EXT;
          end else if (is_shift_code) begin
            shift_d = 1'b1;
          end else if (rx_data == 8'h5A) begin
            cursor_d = enter_pos;
          end else if (print_ok) begin
            if (!repeat_hit) begin
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q;
              wr_char_d = print_char;
              cursor_d  = cur_inc;
`ifdef TYPEMATIC_FILTER_EN
              last_key_d   = rx_data;
              last_valid_d = 1'b1;
`endif
            end
          end else if (rx_data == 8'h66) begin
            if (!repeat_hit) begin
`ifdef TYPEMATIC_FILTER_EN
              last_key_d   = rx_data;
              last_valid_d = 1'b1;
`endif
              if (cursor_q != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cur_dec;
                wr_char_d = 8'h20;
                cursor_d  = cur_dec;
              end
            end
          end
        end
        ST_EXT: begin
          if (rx_data == 8'hF0) begin
            state_d = ST_EXT_BREAK;
          end else begin
            state_d = ST_IDLE;
            if (rx_data == 8'h6B) begin
              cursor_d = cur_dec;
            end else if (rx_data == 8'h74) begin
              cursor_d = cur_inc;
            end
          end
        end
        ST_BREAK: begin
          state_d = ST_IDLE;
          if (is_shift_code) begin
            shift_d = 1'b0;
          end
`ifdef TYPEMATIC_FILTER_EN
          if (last_valid_q && (rx_data == last_key_q)) begin
            last_valid_d = 1'b0;
          end
`endif
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs, asynchronously cleared by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= 1'b0;
      busy_q    <= 1'b0;
      cursor_q  <= '0;
      clr_cnt_q <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_char_q <= 8'h00;
`ifdef TYPEMATIC_FILTER_EN
      last_key_q   <= 8'h00;
      last_valid_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      busy_q    <= busy_d;
      cursor_q  <= cursor_d;
      clr_cnt_q <= clr_cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_char_q <= wr_char_d;
`ifdef TYPEMATIC_FILTER_EN
      last_key_q   <= last_key_d;
      last_valid_q <= last_valid_d;
`endif
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_char      = wr_char_q;
  assign cursor       = cursor_q;
  assign shift_active = shift_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_ps2_char_writer.sv
// Testbench for ps2_char_writer: directed scenarios plus random scancode
// traffic, checked every cycle against a behavioural keyboard/buffer model.
`timescale 1ns/1ps

module tb_ps2_char_writer;

  localparam int W     = 12;
  localparam int CELLS = 108;
  localparam int AW    = 7;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          read_data = 1'b0;
  logic          err = 1'b0;
  logic          clear = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_char;
  logic [AW-1:0] cursor;
  logic          shift_active;
  logic          busy;

  always #5 clk = ~clk;

  ps2_char_writer #(.BUFFER_WIDTH(W), .BUFFER_CELLS(CELLS), .ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_data      (rx_data),
    .read_data    (read_data),
    .err          (err),
    .clear        (clear),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_char      (wr_char),
    .cursor       (cursor),
    .shift_active (shift_active),
    .busy         (busy)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [AW+7:0] exp_q[$];

  // ---------------- reference model ----------------
  int letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                           8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                           8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                           8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  int digit_codes[10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                           8'h3D, 8'h3E, 8'h46};

  int m_cursor, m_clr_next, m_last_addr, m_last_char, m_last_key;
  bit m_shift, m_busy, m_e0, m_f0, m_wr_en, m_last_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int ascii_of(input int code, input bit shifted);
    for (int i = 0; i < 26; i++)
      if (code == letter_codes[i]) return shifted ? (65 + i) : (97 + i);
    for (int i = 0; i < 10; i++)
      if (code == digit_codes[i]) return 48 + i;
    if (code == 8'h29) return 32;
    return -1;
  endfunction

  task automatic model_reset();
    m_cursor = 0; m_clr_next = 0; m_last_addr = 0; m_last_char = 0;
    m_last_key = 0; m_shift = 0; m_busy = 0; m_e0 = 0; m_f0 = 0;
    m_wr_en = 0; m_last_valid = 0;
    exp_q.delete();
  endtask

  task automatic model_write(input int a, input int c);
    logic [AW+7:0] item;
    item = {a[AW-1:0], c[7:0]};
    exp_q.push_back(item);
    m_wr_en = 1;
    m_last_addr = a;
    m_last_char = c;
  endtask

  task automatic model_make(input int code);
    int ch;
    bit rep;
    ch  = ascii_of(code, m_shift);
    rep = 0;
`ifdef TYPEMATIC_FILTER_EN
    if (m_last_valid && m_last_key == code) rep = 1;
`endif
    if (code == 8'h12 || code == 8'h59) begin
      m_shift = 1;
    end else if (code == 8'h5A) begin
      m_cursor = (m_cursor / W + 1) * W;
      if (m_cursor >= CELLS) m_cursor = 0;
    end else if ((ch >= 0 || code == 8'h66) && !rep) begin
`ifdef TYPEMATIC_FILTER_EN
      m_last_key = code;
      m_last_valid = 1;
`endif
      if (ch >= 0) begin
        model_write(m_cursor, ch);
        m_cursor = (m_cursor + 1) % CELLS;
      end else if (m_cursor > 0) begin
        m_cursor = m_cursor - 1;
        model_write(m_cursor, 32);
      end
    end
  endtask

  // Predicts the outputs after the next clock edge for the given inputs.
  task automatic model_step(input bit rd, input int d, input bit e, input bit clr);
    m_wr_en = 0;
    if (m_busy) begin
      if (m_clr_next == CELLS) begin
        m_busy = 0;
        m_cursor = 0;
      end else begin
        model_write(m_clr_next, 32);
        m_clr_next++;
      end
    end else if (clr) begin
      m_busy = 1;
      model_write(0, 32);
      m_clr_next = 1;
    end else if (rd && e) begin
      m_e0 = 0; m_f0 = 0;
    end else if (rd) begin
      if (m_f0) begin
        if (!m_e0) begin
          if (d == 8'h12 || d == 8'h59) m_shift = 0;
`ifdef TYPEMATIC_FILTER_EN
          if (m_last_valid && d == m_last_key) m_last_valid = 0;
`endif
        end
        m_e0 = 0; m_f0 = 0;
      end else if (d == 8'hF0) begin
        m_f0 = 1;
      end else if (d == 8'hE0 && !m_e0) begin
        m_e0 = 1;
      end else if (m_e0) begin
        m_e0 = 0;
        if (d == 8'h6B) m_cursor = (m_cursor + CELLS - 1) % CELLS;
        else if (d == 8'h74) m_cursor = (m_cursor + 1) % CELLS;
      end else begin
        model_make(d);
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [AW+7:0] item;
    chk({tag, ".wr_en"}, wr_en, m_wr_en);
    if (m_wr_en && exp_q.size() > 0) begin
      item = exp_q.pop_front();
      chk({tag, ".wr_addr"}, wr_addr, item[AW+7:8]);
      chk({tag, ".wr_char"}, wr_char, item[7:0]);
    end else begin
      chk({tag, ".wr_addr_hold"}, wr_addr, m_last_addr);
      chk({tag, ".wr_char_hold"}, wr_char, m_last_char);
    end
    chk({tag, ".cursor"}, cursor, m_cursor);
    chk({tag, ".shift"}, shift_active, m_shift);
    chk({tag, ".busy"}, busy, m_busy);
  endtask

  // ---------------- driver tasks ----------------
  // Called at posedge+2: apply inputs, predict, clock once, check.
  task automatic step(input bit rd, input logic [7:0] d, input bit e, input bit clr);
    rx_data = d; read_data = rd; err = e; clear = clr;
    model_step(rd, d, e, clr);
    @(posedge clk); #2;
    read_data = 1'b0; err = 1'b0; clear = 1'b0;
    check_all("step");
  endtask

  task automatic strobe(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0);
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    chk("rst.wr_en", wr_en, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_char", wr_char, 0);
    chk("rst.cursor", cursor, 0);
    chk("rst.shift", shift_active, 0);
    chk("rst.busy", busy, 0);
    model_reset();
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  function automatic logic [7:0] pick_code();
    int r;
    r = $urandom_range(0, 9);
    case (r)
      0, 1, 2: return 8'(letter_codes[$urandom_range(0, 25)]);
      3:       return 8'(digit_codes[$urandom_range(0, 9)]);
      4:       return 8'hF0;
      5:       return 8'hE0;
      6: begin
        case ($urandom_range(0, 4))
          0: return 8'h12;
          1: return 8'h59;
          2: return 8'h5A;
          3: return 8'h66;
          default: return 8'h29;
        endcase
      end
      7:       return ($urandom_range(0, 1) == 0) ? 8'h6B : 8'h74;
      8:       return 8'($urandom_range(0, 255));
      default: return 8'h1C;
    endcase
  endfunction

  // ---------------- directed + random sequence ----------------
  initial begin : main
    int busy_cycles;
    do_reset();

    // Single letter at the home position.
    strobe(8'h1C);
    chk("r034.addr", wr_addr, 0);
    chk("r034.char", wr_char, 8'h61);
    chk("r034.cursor", cursor, 1);

    // Backspace back to 0, then Backspace at 0 does nothing.
    strobe(8'h66);
    strobe(8'h66);
    chk("r037.no_write", wr_en, 0);
    strobe(8'h16);
    chk("r037.digit1", wr_char, 8'h31);
    strobe(8'h66);
    chk("r037.bs_char", wr_char, 8'h20);
    chk("r037.cursor", cursor, 0);

    // Left arrow wraps to the last cell, digit there wraps cursor to 0.
    strobe(8'hE0);
    strobe(8'h6B);
    chk("r036.cursor_last", cursor, CELLS - 1);
    strobe(8'h45);
    chk("r036.addr", wr_addr, CELLS - 1);
    chk("r036.char", wr_char, 8'h30);
    chk("r036.cursor_wrap", cursor, 0);
    strobe(8'hE0); strobe(8'h6B);
    strobe(8'hE0); strobe(8'h74);
    chk("right_wrap", cursor, 0);

    // Shift make/break around letters.
    strobe(8'h12);
    strobe(8'h1C);
    chk("r035.upper", wr_char, 8'h41);
    strobe(8'hF0); strobe(8'h12);
    strobe(8'h1C);
    chk("r035.lower", wr_char, 8'h61);
    chk("r035.addr", wr_addr, 1);
    chk("r035.shift", shift_active, 0);

    // Enter from row 0 and from the last row.
    strobe(8'h5A);
    chk("enter.row1", cursor, W);
    for (int i = 0; i < 13; i++) begin
      strobe(8'hE0); strobe(8'h6B);
    end
    strobe(8'h5A);
    chk("enter.last_row", cursor, 0);

    // Errored bytes reset the prefix decoding.
    strobe(8'hE0);
    step(1'b1, 8'h6B, 1'b1, 1'b0);
    strobe(8'h6B);
    chk("err.ext_dropped", cursor, 0);
    strobe(8'hF0);
    step(1'b1, 8'h1C, 1'b1, 1'b0);
    strobe(8'h1C);
    chk("err.brk_dropped", wr_char, 8'h61);

    // Typematic repeat behaviour.
    do_reset();
    strobe(8'h1C);
    strobe(8'h1C);
`ifdef TYPEMATIC_FILTER_EN
    chk("r039.cursor", cursor, 1);
`else
    chk("r039.cursor", cursor, 2);
`endif
    strobe(8'hF0); strobe(8'h1C);
    strobe(8'h1C);

    // Clear sweep, with colliding strobe/clear traffic and Shift held.
    strobe(8'h12);
    busy_cycles = 0;
    step(1'b1, 8'h1C, 1'b0, 1'b1);
    if (busy === 1'b1) busy_cycles++;
    strobe(8'h1C);
    if (busy === 1'b1) busy_cycles++;
    step(1'b0, 8'h00, 1'b0, 1'b1);
    if (busy === 1'b1) busy_cycles++;
    strobe(8'hF0);
    if (busy === 1'b1) busy_cycles++;
    strobe(8'h12);
    if (busy === 1'b1) busy_cycles++;
    for (int i = 0; i < 200 && busy === 1'b1; i++) begin
      idle();
      if (busy === 1'b1) busy_cycles++;
    end
    chk("r038.busy_cycles", busy_cycles, CELLS);
    chk("r038.cursor", cursor, 0);
    chk("r038.shift_held", shift_active, 1);

    // Reset in the middle of a sweep aborts it.
    step(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (20) idle();
    do_reset();
    repeat (10) idle();

    // Random traffic.
    for (int i = 0; i < 700; i++) begin
      step($urandom_range(0, 3) != 0, pick_code(),
           $urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 120 && m_busy; i++) idle();

    chk("exp_q_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
